fifo_frame_writer: RTL

Write-side producer for the asynchronous FIFO. It accepts a frame command of length N and N payload words from an upstream valid/ready source, all in the `wr_clk` domain. It emits a framed word stream into the FIFO write port: a header word, N payload words, then an XOR checksum trailer. It never writes while `full_flag` is high, so no words are dropped or duplicated under back-pressure. It also provides per-frame status for the write-side control logic.

---
 rtl/fifo_frame_writer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fifo_frame_writer.sv
// Frame producer for the async FIFO write port.
// Emits header (length), payload words, XOR trailer.
module fifo_frame_writer #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             wr_clk,
  input  logic             wr_rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             full_flag,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             frame_done,
  output logic             cmd_err,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    TRL  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rem_q;
  logic [WIDTH-1:0] csum_q;
  logic             done_q;
  logic             err_q;
  logic [15:0]      frame_cnt_q;
  logic [15:0]      frame_cnt_d;
  logic             cmd_ok;

  assign cmd_ok = (cmd_len != '0) && (cmd_len <= MAX_L);

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;
  assign cmd_err    = err_q;
  assign frame_cnt  = frame_cnt_q;

  // Write strobe and data, qualified by full so each strobe is one write.
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = '0;
    in_ready = 1'b0;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      HDR: begin
        wr_en   = ~full_flag;
        wr_data = WIDTH'(len_q);
      end
      PAY: begin
        in_ready = ~full_flag;
        wr_en    = in_valid & ~full_flag;
        wr_data  = in_data;
      end
      TRL: begin
        wr_en   = ~full_flag;
        wr_data = csum_q;
        if (~full_flag) frame_cnt_d = frame_cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  // Frame sequencer with length/checksum tracking and status pulses.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      csum_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= frame_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_ok) begin
              len_q   <= cmd_len;
              rem_q   <= cmd_len;
              csum_q  <= '0;
              state_q <= HDR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        HDR: begin
          if (wr_en) state_q <= PAY;
        end
        PAY: begin
          if (wr_en) begin
            csum_q <= csum_q ^ in_data;
            rem_q  <= rem_q - ONE_L;
            if (rem_q == ONE_L) state_q <= TRL;
          end
        end
        TRL: begin
          if (wr_en) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
